reduce_adder_sched: RTL

- Shares one pipelined floating-point adder (fixed latency AdderLatency) between the reduction-table slots of a reduction unit.
- Each slot raises a request carrying its accumulator operand and an incoming payload; the block grants one slot per cycle in round-robin order and drives the adder inputs.
- It tracks the slot tag down a shadow pipeline and returns sum plus slot index as a writeback strobe, exactly when the adder output is valid.
- It blocks a second issue from a slot whose previous add is still in flight, which removes read-after-write hazards on the accumulator.

---
 rtl/reduce_adder_sched_pkg.sv | 21 ++
 rtl/reduce_adder_sched_if.sv | 31 +++
 rtl/reduce_adder_sched_rr_arbiter.sv | 56 +++++
 rtl/reduce_adder_sched.sv | 105 ++++++++++
 4 files changed

// File: rtl/reduce_adder_sched_pkg.sv
// rtl/reduce_adder_sched_pkg.sv - shared reduction-unit sizing and adder tag layout
package reduce_pkg;

    localparam int NumSlots     = 6;
    localparam int SlotIdxWidth = 3;
    localparam int PayloadWidth = 32;
    localparam int AdderLatency = 14;
    localparam int CntWidth     = SlotIdxWidth + 1;

    typedef struct packed {
        logic                    valid;
        logic [SlotIdxWidth-1:0] slot;
    } tag_t;

    function automatic logic [NumSlots-1:0] slot_mask(input logic [SlotIdxWidth-1:0] s);
        logic [NumSlots-1:0] one;
        one = {{(NumSlots-1){1'b0}}, 1'b1};
        return one << s;
    endfunction

endpackage

// File: rtl/reduce_adder_sched_if.sv
// rtl/reduce_adder_sched_if.sv - slot request, adder and writeback bundle
interface reduce_adder_sched_if;
    import reduce_pkg::*;

    logic [NumSlots-1:0]              req;
    logic [NumSlots*PayloadWidth-1:0] req_a;
    logic [NumSlots*PayloadWidth-1:0] req_b;
    logic [NumSlots-1:0]              grant;
    logic [PayloadWidth-1:0]          add_a;
    logic [PayloadWidth-1:0]          add_b;
    logic                             add_valid;
    logic [PayloadWidth-1:0]          add_sum;
    logic                             wb_valid;
    logic [SlotIdxWidth-1:0]          wb_slot;
    logic [PayloadWidth-1:0]          wb_sum;
    logic [NumSlots-1:0]              inflight;
    logic [CntWidth-1:0]              inflight_cnt;

    modport master (
        output req, req_a, req_b, add_sum,
        input  grant, add_a, add_b, add_valid, wb_valid, wb_slot, wb_sum,
               inflight, inflight_cnt
    );

    modport slave (
        input  req, req_a, req_b, add_sum,
        output grant, add_a, add_b, add_valid, wb_valid, wb_slot, wb_sum,
               inflight, inflight_cnt
    );

endinterface

// File: rtl/reduce_adder_sched_rr_arbiter.sv
// rtl/reduce_adder_sched_rr_arbiter.sv - round-robin arbiter, one-hot grant plus index
module rr_arbiter
    import reduce_pkg::*;
#(
    parameter int N  = NumSlots,
    parameter int IW = SlotIdxWidth
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  elig_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_valid_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;
    logic [IW-1:0] cand_idx;

    // Scan from ptr upward, wrapping at N, and take the first eligible slot.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        cand_idx      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            cand_idx = cand[IW-1:0];
            if (!grant_valid_o && elig_i[cand_idx]) begin
                grant_valid_o     = 1'b1;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            ptr_d = (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reduce_adder_sched.sv
// rtl/reduce_adder_sched.sv - shares one pipelined adder among reduction slots
module reduce_adder_sched
    import reduce_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    reduce_adder_sched_if.slave bus
);

    logic [NumSlots-1:0]     elig;
    logic [NumSlots-1:0]     grant;
    logic [SlotIdxWidth-1:0] grant_idx;
    logic                    grant_valid;

    logic [PayloadWidth-1:0] add_a_q, add_a_d;
    logic [PayloadWidth-1:0] add_b_q, add_b_d;
    logic                    add_valid_q, add_valid_d;
    tag_t                    tag_q [AdderLatency];
    tag_t                    tag_d [AdderLatency];
    tag_t                    wb_q, wb_d;
    logic [NumSlots-1:0]     inflight_q, inflight_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic [NumSlots-1:0]     clr_mask;

    // A slot with an add still in the adder may not issue again.
    assign elig = bus.req & ~inflight_q;

    rr_arbiter #(
        .N  (NumSlots),
        .IW (SlotIdxWidth)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .elig_i        (elig),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_valid_d = grant_valid;
        if (grant_valid) begin
            add_a_d = bus.req_a[grant_idx*PayloadWidth +: PayloadWidth];
            add_b_d = bus.req_b[grant_idx*PayloadWidth +: PayloadWidth];
        end
    end

    // Shadow pipe runs alongside the adder; wb register adds the final stage of latency.
    always_comb begin
        tag_d[0].valid = grant_valid;
        tag_d[0].slot  = grant_idx;
        for (int k = 1; k < AdderLatency; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        wb_d = tag_q[AdderLatency-1];
    end

    always_comb begin
        clr_mask   = wb_q.valid ? slot_mask(wb_q.slot) : '0;
        inflight_d = (inflight_q & ~clr_mask) | grant;
        cnt_d      = cnt_q;
        case ({grant_valid, wb_q.valid})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_valid_q <= 1'b0;
            for (int k = 0; k < AdderLatency; k++) begin
                tag_q[k] <= '0;
            end
            wb_q        <= '0;
            inflight_q  <= '0;
            cnt_q       <= '0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_valid_q <= add_valid_d;
            for (int k = 0; k < AdderLatency; k++) begin
                tag_q[k] <= tag_d[k];
            end
            wb_q        <= wb_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.grant        = grant;
    assign bus.add_a        = add_a_q;
    assign bus.add_b        = add_b_q;
    assign bus.add_valid    = add_valid_q;
    assign bus.wb_valid     = wb_q.valid;
    assign bus.wb_slot      = wb_q.slot;
    assign bus.wb_sum       = bus.add_sum;
    assign bus.inflight     = inflight_q;
    assign bus.inflight_cnt = cnt_q;

endmodule
